// File: rtl/alu_md.sv
// alu_md: registered ALU for the EX stage with a start/done handshake.
// Simple ops finish one cycle after start; multiply/divide iterate one bit
// per cycle and produce a double-width result on {hi, r}.
// Ports:
//   clk, rst (sync, active-high), start, op[4:0], a, b   inputs
//   busy, done, r, hi, zero, carry, negative, overflow, dz, illegal   outputs
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             dz,
  output logic             illegal
);
  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t state_r, state_s;

  logic [SW-1:0]    cnt_r;
  logic             is_div_r, neg_res_r, rem_neg_r, bz_r, ovf_r, signed_r;
  logic [WIDTH-1:0] a_r, mag_b_r, p_hi_r, p_lo_r;

  logic accept_s, md_go_s, bad_op_s;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[MSB]) begin
      return {WIDTH{1'b0}} - x;
    end else begin
      return x;
    end
  endfunction

  assign accept_s = (state_r == IDLE) && start;
  assign bad_op_s = op[4] && (op[3:2] != 2'b00);
  assign md_go_s  = accept_s && op[4] && (op[3:2] == 2'b00);

  // Simple-op result and flags, evaluated from the live inputs.
  logic [WIDTH:0]   sum_s, diff_s;
  logic [WIDTH-1:0] s_r_s;
  logic [SW-1:0]    sh_s, sh_m1_s, sh_neg_s;
  logic             s_c_s, s_v_s, s_n_s, s_z_s, lt_u_s, lt_s_s;

  // Decode and compute the single-cycle ops.
  always_comb begin
    sum_s    = {1'b0, a} + {1'b0, b};
    diff_s   = {1'b0, a} - {1'b0, b};
    lt_u_s   = diff_s[WIDTH];
    lt_s_s   = $signed(a) < $signed(b);
    sh_s     = a[SW-1:0];
    sh_m1_s  = sh_s - {{(SW-1){1'b0}}, 1'b1};
    // Index of the last bit shifted out on a left shift: WIDTH - sh, mod WIDTH.
    sh_neg_s = {SW{1'b0}} - sh_s;
    s_r_s    = {WIDTH{1'b0}};
    s_c_s    = 1'b0;
    s_v_s    = 1'b0;
    case (op[3:0])
      4'b0000: begin s_r_s = sum_s[MSB:0]; s_c_s = sum_s[WIDTH]; end
      4'b0001: begin s_r_s = diff_s[MSB:0]; s_c_s = lt_u_s; end
      4'b0010: begin
        s_r_s = sum_s[MSB:0];
        s_v_s = (a[MSB] == b[MSB]) && (sum_s[MSB] != a[MSB]);
      end
      4'b0011: begin
        s_r_s = diff_s[MSB:0];
        s_v_s = (a[MSB] != b[MSB]) && (diff_s[MSB] != a[MSB]);
      end
      4'b0100: s_r_s = a & b;
      4'b0101: s_r_s = a | b;
      4'b0110: s_r_s = a ^ b;
      4'b0111: s_r_s = ~(a | b);
      4'b1000, 4'b1001: s_r_s = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      4'b1010: begin s_r_s = {{(WIDTH-1){1'b0}}, lt_u_s}; s_c_s = lt_u_s; end
      4'b1011: s_r_s = {{(WIDTH-1){1'b0}}, lt_s_s};
      4'b1100: begin
        s_r_s = $signed(b) >>> sh_s;
        s_c_s = (sh_s != {SW{1'b0}}) ? b[sh_m1_s] : 1'b0;
      end
      4'b1101: begin
        s_r_s = b >> sh_s;
        s_c_s = (sh_s != {SW{1'b0}}) ? b[sh_m1_s] : 1'b0;
      end
      default: begin
        s_r_s = b << sh_s;
        s_c_s = (sh_s != {SW{1'b0}}) ? b[sh_neg_s] : 1'b0;
      end
    endcase
    // Set-less-than reports operand equality in zero rather than result == 0.
    if (op[3:1] == 3'b101) begin
      s_z_s = (a == b);
      s_n_s = op[0] ? lt_s_s : s_r_s[MSB];
    end else begin
      s_z_s = (s_r_s == {WIDTH{1'b0}});
      s_n_s = s_r_s[MSB];
    end
  end

  // One iteration of shift-add multiply / restoring divide, plus final fix-up.
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH+1:0]   div_trial_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   md_r_s, md_hi_s;
  logic               md_z_s, md_n_s;

  // Iteration datapath and sign correction for the FIX cycle.
  always_comb begin
    mul_sum_s   = {1'b0, p_hi_r} + (p_lo_r[0] ? {1'b0, mag_b_r} : {(WIDTH+1){1'b0}});
    div_trial_s = {1'b0, p_hi_r, p_lo_r[MSB]} - {2'b00, mag_b_r};
    prod_s      = {p_hi_r, p_lo_r};
    prod_fix_s  = neg_res_r ? ({(2*WIDTH){1'b0}} - prod_s) : prod_s;
    if (!is_div_r) begin
      md_r_s  = prod_fix_s[MSB:0];
      md_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
      md_n_s  = md_hi_s[MSB];
      md_z_s  = (prod_fix_s == {(2*WIDTH){1'b0}});
    end else if (bz_r) begin
      md_r_s  = {WIDTH{1'b1}};
      md_hi_s = a_r;
      md_n_s  = 1'b1;
      md_z_s  = 1'b0;
    end else begin
      md_r_s  = neg_res_r ? ({WIDTH{1'b0}} - p_lo_r) : p_lo_r;
      md_hi_s = rem_neg_r ? ({WIDTH{1'b0}} - p_hi_r) : p_hi_r;
      md_n_s  = md_r_s[MSB];
      md_z_s  = ({md_hi_s, md_r_s} == {(2*WIDTH){1'b0}});
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (md_go_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == {SW{1'b0}}) begin
          state_s = FIX;
        end else begin
          state_s = RUN;
        end
      end
      FIX:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; busy is registered alongside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
    end
  end

  // Operand capture, iteration registers and registered results/flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {SW{1'b0}};
      is_div_r <= 1'b0; neg_res_r <= 1'b0; rem_neg_r <= 1'b0;
      bz_r <= 1'b0; ovf_r <= 1'b0; signed_r <= 1'b0;
      a_r <= {WIDTH{1'b0}}; mag_b_r <= {WIDTH{1'b0}};
      p_hi_r <= {WIDTH{1'b0}}; p_lo_r <= {WIDTH{1'b0}};
      done <= 1'b0; r <= {WIDTH{1'b0}}; hi <= {WIDTH{1'b0}};
      zero <= 1'b0; carry <= 1'b0; negative <= 1'b0;
      overflow <= 1'b0; dz <= 1'b0; illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept_s && !op[4]) begin
        done <= 1'b1; r <= s_r_s; hi <= {WIDTH{1'b0}};
        zero <= s_z_s; carry <= s_c_s; negative <= s_n_s;
        overflow <= s_v_s; dz <= 1'b0; illegal <= 1'b0;
      end else if (accept_s && bad_op_s) begin
        done <= 1'b1; r <= {WIDTH{1'b0}}; hi <= {WIDTH{1'b0}};
        zero <= 1'b0; carry <= 1'b0; negative <= 1'b0;
        overflow <= 1'b0; dz <= 1'b0; illegal <= 1'b1;
      end else if (md_go_s) begin
        cnt_r     <= SW'(WIDTH - 1);
        is_div_r  <= op[1];
        signed_r  <= op[0];
        neg_res_r <= op[0] && (a[MSB] ^ b[MSB]);
        rem_neg_r <= op[0] && a[MSB];
        bz_r      <= (b == {WIDTH{1'b0}});
        ovf_r     <= (op[1:0] == 2'b11) && (a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                     (b == {WIDTH{1'b1}});
        a_r       <= a;
        mag_b_r   <= magnitude(b, op[0]);
        p_hi_r    <= {WIDTH{1'b0}};
        p_lo_r    <= magnitude(a, op[0]);
      end else if (state_r == RUN) begin
        cnt_r <= cnt_r - {{(SW-1){1'b0}}, 1'b1};
        if (!is_div_r) begin
          {p_hi_r, p_lo_r} <= {mul_sum_s, p_lo_r[MSB:1]};
        end else if (!div_trial_s[WIDTH+1]) begin
          p_hi_r <= div_trial_s[MSB:0];
          p_lo_r <= {p_lo_r[MSB-1:0], 1'b1};
        end else begin
          p_hi_r <= {p_hi_r[MSB-1:0], p_lo_r[MSB]};
          p_lo_r <= {p_lo_r[MSB-1:0], 1'b0};
        end
      end else if (state_r == FIX) begin
        done <= 1'b1; r <= md_r_s; hi <= md_hi_s;
        zero <= md_z_s; carry <= 1'b0; negative <= md_n_s;
        overflow <= is_div_r && signed_r && ovf_r;
        dz <= is_div_r && bz_r; illegal <= 1'b0;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: a table of directed vectors (simple and
// multiply/divide ops) plus hand-written sequences for ignored start, reset
// mid-operation, reset priority and an 8-bit instance.
module tb_alu_md;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [4:0]  op;
  logic [31:0] a, b, r, hi;
  logic        busy, done, zero, carry, negative, overflow, dz, illegal;
  logic [5:0]  fl;
  assign fl = {zero, carry, negative, overflow, dz, illegal};

  logic       start8;
  logic [4:0] op8;
  logic [7:0] a8, b8, r8, hi8;
  logic       busy8, done8, zero8, carry8, negative8, overflow8, dz8, illegal8;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .r(r), .hi(hi), .zero(zero), .carry(carry),
    .negative(negative), .overflow(overflow), .dz(dz), .illegal(illegal));

  alu_md #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .r(r8), .hi(hi8), .zero(zero8), .carry(carry8),
    .negative(negative8), .overflow(overflow8), .dz(dz8), .illegal(illegal8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // flags order: {zero, carry, negative, overflow, dz, illegal}
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, r, hi;
    logic [5:0]  fl;
    int          lat;
  } vec_t;

  vec_t tv[25];

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    for (int c = 1; c < v.lat; c++) begin
      chk("busy_run", {62'd0, done, busy}, 64'd1);
      @(negedge clk);
    end
    chk("done", {63'd0, done}, 64'd1);
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("r", {32'd0, r}, {32'd0, v.r});
    chk("hi", {32'd0, hi}, {32'd0, v.hi});
    chk("flags", {58'd0, fl}, {58'd0, v.fl});
  endtask

  initial begin
    logic seen;
    tv[0]  = '{5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 6'b110000, 1};
    tv[1]  = '{5'b00010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 6'b001100, 1};
    tv[2]  = '{5'b01100, 32'h00000004, 32'h80000000, 32'hF8000000, 32'h0, 6'b001000, 1};
    tv[3]  = '{5'b01101, 32'h00000005, 32'h00000010, 32'h00000000, 32'h0, 6'b110000, 1};
    tv[4]  = '{5'b01011, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 6'b001000, 1};
    tv[5]  = '{5'b01010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 6'b000000, 1};
    tv[6]  = '{5'b00001, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 32'h0, 6'b011000, 1};
    tv[7]  = '{5'b00011, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 6'b000100, 1};
    tv[8]  = '{5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0, 6'b001000, 1};
    tv[9]  = '{5'b00101, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 32'h0, 6'b000000, 1};
    tv[10] = '{5'b00110, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 32'h0, 6'b100000, 1};
    tv[11] = '{5'b00111, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 6'b001000, 1};
    tv[12] = '{5'b01000, 32'h00000000, 32'h1234ABCD, 32'hABCD0000, 32'h0, 6'b001000, 1};
    tv[13] = '{5'b01001, 32'h00000000, 32'h00005678, 32'h56780000, 32'h0, 6'b000000, 1};
    tv[14] = '{5'b01110, 32'h00000001, 32'h80000001, 32'h00000002, 32'h0, 6'b010000, 1};
    tv[15] = '{5'b01111, 32'h00000000, 32'h00000005, 32'h00000005, 32'h0, 6'b000000, 1};
    tv[16] = '{5'b01101, 32'h00000020, 32'h00000003, 32'h00000003, 32'h0, 6'b000000, 1};
    tv[17] = '{5'b10111, 32'h00000005, 32'h00000006, 32'h00000000, 32'h0, 6'b000001, 1};
    tv[18] = '{5'b10001, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFF1, 32'hFFFFFFFF, 6'b001000, 34};
    tv[19] = '{5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 6'b001000, 34};
    tv[20] = '{5'b10011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 6'b001000, 34};
    tv[21] = '{5'b10010, 32'd100,      32'h00000000, 32'hFFFFFFFF, 32'd100,      6'b001010, 34};
    tv[22] = '{5'b10011, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 6'b001100, 34};
    tv[23] = '{5'b10010, 32'd100,      32'd7,        32'd14,       32'd2,        6'b000000, 34};
    tv[24] = '{5'b10000, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 6'b100000, 34};

    rst = 1'b1; start = 1'b0; op = 5'd0; a = 32'd0; b = 32'd0;
    start8 = 1'b0; op8 = 5'd0; a8 = 8'd0; b8 = 8'd0;
    cycles(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    chk("rst_r_hi", {r, hi}, 64'd0);
    chk("rst_flags", {58'd0, fl}, 64'd0);
    chk("rst8_outs", {46'd0, busy8, done8, r8, hi8}, 64'd0);

    for (int i = 0; i < 25; i++) run_vec(tv[i]);

    // Start while busy is ignored: ADDU offered in cycle 5 of a MULTU.
    @(negedge clk);
    op = 5'b10000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(4);
    op = 5'b00000; a = 32'd1; b = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_no_done", {62'd0, done, busy}, 64'd1);
    cycles(28);
    chk("ign_done", {63'd0, done}, 64'd1);
    chk("ign_result", {hi, r}, 64'hFFFFFFFE_00000001);

    // Reset in cycle 10 of a DIVU aborts it with no done.
    @(negedge clk);
    op = 5'b10010; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
    chk("abort_r_hi", {r, hi}, 64'd0);
    chk("abort_flags", {58'd0, fl}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);

    // Reset wins over a simultaneous start.
    op = 5'b00000; a = 32'hFFFFFFFF; b = 32'd1; start = 1'b1; rst = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("rst_prio", {61'd0, done, busy, zero}, 64'd0);

    // 8-bit instance: MULT -128 x -128.
    op8 = 5'b10001; a8 = 8'h80; b8 = 8'h80; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cycles(8);
    chk("w8_busy_c9", {62'd0, done8, busy8}, 64'd1);
    @(negedge clk);
    chk("w8_done_c10", {62'd0, done8, busy8}, 64'd2);
    chk("w8_result", {48'd0, hi8, r8}, 64'h4000);
    chk("w8_neg", {63'd0, negative8}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
